step_motor_ramp_gen: RTL and testbench

Parametrised step-pulse generator with trapezoidal acceleration, replacing the fixed speed-table divider. It accepts a move command made of a step count, a direction and a target half-period. It then ramps the step rate from a start speed up to the target, cruises, and decelerates symmetrically so the last step lands at start speed. It sits between the motion-command logic and the motor driver's STEP/DIR pins.

---
 rtl/step_motor_ramp_gen.sv | 120 ++++++++++++
 tb/tb_step_motor_ramp_gen.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/step_motor_ramp_gen.sv
// step_motor_ramp_gen: STEP/DIR pulse generator with a trapezoidal speed ramp.
// Half-periods shrink by RAMP_DELTA per step up to the target, then grow back so the last step runs at START_HALF.
module step_motor_ramp_gen #(
  parameter int CNT_W      = 24,
  parameter int STEP_W     = 16,
  parameter int START_HALF = 375000,
  parameter int RAMP_DELTA = 12500
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              dir,
  input  logic [STEP_W-1:0] num_steps,
  input  logic [CNT_W-1:0]  target_half,
  input  logic              abort,
  output logic              step_pulse,
  output logic              dir_out,
  output logic              busy,
  output logic              done,
  output logic [STEP_W-1:0] steps_left
);
  typedef enum logic [1:0] {IDLE, ACCEL, RUN, DECEL} state_t;
  localparam logic [CNT_W-1:0] START_H = CNT_W'(START_HALF);
  localparam logic [CNT_W-1:0] DELTA   = CNT_W'(RAMP_DELTA);
  state_t state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt, cur_half, cur_nxt, tgt, tgt_nxt, tgt_in, dec_half, inc_half;
  logic [CNT_W:0] inc_sum;
  logic [STEP_W-1:0] accel_steps, acc_nxt, left_nxt, left_dec;
  logic pulse_nxt, dir_nxt, busy_nxt, done_nxt, pend, pend_nxt;
  logic edge_t, rise, fall, abort_now;
  always_comb begin
    tgt_in    = (target_half < CNT_W'(2)) ? CNT_W'(2) : target_half;
    edge_t    = busy && (cnt == cur_half - CNT_W'(1));
    rise      = edge_t && !step_pulse;
    fall      = edge_t && step_pulse;
    abort_now = abort || pend;
    left_dec  = steps_left - STEP_W'(1);
    dec_half  = (cur_half - tgt > DELTA) ? cur_half - DELTA : tgt;
    inc_sum   = {1'b0, cur_half} + {1'b0, DELTA};
    // deceleration only ever slows down; halves already slower than START_HALF stay put
    inc_half  = (cur_half >= START_H) ? cur_half :
                (inc_sum > {1'b0, START_H}) ? START_H : inc_sum[CNT_W-1:0];
    state_nxt = state;
    cnt_nxt   = cnt;
    cur_nxt   = cur_half;
    tgt_nxt   = tgt;
    acc_nxt   = accel_steps;
    left_nxt  = steps_left;
    pulse_nxt = step_pulse;
    dir_nxt   = dir_out;
    busy_nxt  = busy;
    done_nxt  = 1'b0;
    pend_nxt  = pend;
    if (state == IDLE) begin
      if (start && num_steps == '0) begin
        done_nxt = 1'b1;
      end else if (start) begin
        busy_nxt  = 1'b1;
        dir_nxt   = dir;
        left_nxt  = num_steps;
        cnt_nxt   = '0;
        acc_nxt   = '0;
        pulse_nxt = 1'b0;
        pend_nxt  = 1'b0;
        tgt_nxt   = tgt_in;
        cur_nxt   = (tgt_in >= START_H) ? tgt_in : START_H;
        state_nxt = (tgt_in >= START_H) ? RUN : ACCEL;
      end
    end else if ((!step_pulse && abort_now) || (fall && (steps_left == '0 || abort_now))) begin
      busy_nxt  = 1'b0;
      done_nxt  = 1'b1;
      pulse_nxt = 1'b0;
      pend_nxt  = 1'b0;
      cnt_nxt   = '0;
      state_nxt = IDLE;
    end else begin
      pend_nxt  = pend || abort;
      cnt_nxt   = edge_t ? '0 : cnt + CNT_W'(1);
      pulse_nxt = edge_t ? !step_pulse : step_pulse;
      if (rise) begin
        left_nxt = left_dec;
        if (state == DECEL || left_dec <= accel_steps) begin
          state_nxt = DECEL;
          cur_nxt   = inc_half;
        end else if (state == ACCEL) begin
          cur_nxt   = dec_half;
          acc_nxt   = (accel_steps == '1) ? accel_steps : accel_steps + STEP_W'(1);
          state_nxt = (dec_half == tgt) ? RUN : ACCEL;
        end
      end
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      cur_half    <= '0;
      tgt         <= '0;
      accel_steps <= '0;
      steps_left  <= '0;
      step_pulse  <= 1'b0;
      dir_out     <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      pend        <= 1'b0;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      cur_half    <= cur_nxt;
      tgt         <= tgt_nxt;
      accel_steps <= acc_nxt;
      steps_left  <= left_nxt;
      step_pulse  <= pulse_nxt;
      dir_out     <= dir_nxt;
      busy        <= busy_nxt;
      done        <= done_nxt;
      pend        <= pend_nxt;
    end
  end
endmodule

// File: tb/tb_step_motor_ramp_gen.sv
// tb_step_motor_ramp_gen: directed checks of ramp shape, abort, reset and ignored inputs.
module tb_step_motor_ramp_gen;
  localparam int CW = 24;
  localparam int SW = 16;
  logic clk = 0, rst = 1, start = 0, dir = 0, abort = 0;
  logic [SW-1:0] num_steps = '0;
  logic [CW-1:0] target_half = '0;
  logic step_pulse, dir_out, busy, done;
  logic [SW-1:0] steps_left;
  int total = 0, bad = 0;
  int halves[$];
  int e[$];
  int run = 0, busy_cyc = 0, done_cnt = 0, rises = 0;
  logic prev = 0;
  int h0, b0, r0, d0;
  always #5 clk = ~clk;
  step_motor_ramp_gen #(.CNT_W(CW), .STEP_W(SW), .START_HALF(8), .RAMP_DELTA(2)) dut (
    .clk(clk), .rst(rst), .start(start), .dir(dir), .num_steps(num_steps),
    .target_half(target_half), .abort(abort), .step_pulse(step_pulse), .dir_out(dir_out),
    .busy(busy), .done(done), .steps_left(steps_left)
  );
  // run-length log of step_pulse while busy
  always @(negedge clk) begin
    if (busy) begin
      if (run > 0 && step_pulse !== prev) begin
        halves.push_back(run);
        run = 1;
        if (step_pulse) rises++;
      end else run++;
      prev = step_pulse;
      busy_cyc++;
    end else if (run > 0) begin
      halves.push_back(run);
      run = 0;
    end
    if (done) done_cnt++;
  end
  task automatic chk(string tag, int obs, int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%0d exp=%0d", tag, obs, exp);
    end
  endtask
  task automatic chk_halves(string tag);
    chk({tag, "_nhalves"}, halves.size() - h0, e.size());
    for (int i = 0; i < e.size(); i++)
      chk($sformatf("%s_half%0d", tag, i), (h0 + i < halves.size()) ? halves[h0 + i] : -1, e[i]);
  endtask
  task automatic snap();
    h0 = halves.size(); b0 = busy_cyc; r0 = rises; d0 = done_cnt;
  endtask
  task automatic start_move(logic d, int n, int t);
    snap();
    @(negedge clk);
    dir = d; num_steps = SW'(n); target_half = CW'(t); start = 1;
    @(negedge clk);
    start = 0;
  endtask
  task automatic wait_idle(string tag, int limit);
    int ok;
    ok = 0;
    for (int i = 0; i < limit && !ok; i++) begin
      @(negedge clk);
      if (!busy) ok = 1;
    end
    if (!ok) begin
      total++; bad++;
      $error("FAIL %s_timeout obs=busy exp=idle", tag);
    end
  endtask
  task automatic wait_for(string tag, int sl, logic sp, int limit);
    int ok;
    ok = 0;
    for (int i = 0; i < limit && !ok; i++) begin
      @(negedge clk);
      if (steps_left == SW'(sl) && step_pulse == sp) ok = 1;
    end
    if (!ok) begin
      total++; bad++;
      $error("FAIL %s_wait obs=%0d exp=%0d", tag, steps_left, sl);
    end
  endtask
  task automatic end_checks(string tag, int busy_exp, int rise_exp, int left_exp);
    chk({tag, "_done"}, int'(done), 1);
    @(negedge clk);
    chk({tag, "_done_once"}, done_cnt - d0, 1);
    chk({tag, "_busy_cyc"}, busy_cyc - b0, busy_exp);
    chk({tag, "_rises"}, rises - r0, rise_exp);
    chk({tag, "_left"}, int'(steps_left), left_exp);
  endtask
  task automatic ramp6(string tag);
    start_move(1, 6, 4);
    chk({tag, "_busy"}, int'(busy), 1);
    chk({tag, "_dir"}, int'(dir_out), 1);
    chk({tag, "_left0"}, int'(steps_left), 6);
    wait_idle(tag, 200);
    end_checks(tag, 72, 6, 0);
    e = '{8, 6, 6, 4, 4, 4, 4, 6, 6, 8, 8, 8};
    chk_halves(tag);
  endtask
  initial begin
    repeat (3) @(negedge clk);
    chk("rst_pulse", int'(step_pulse), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_left", int'(steps_left), 0);
    chk("rst_dir", int'(dir_out), 0);
    rst = 0;
    @(negedge clk);
    ramp6("ramp");
    start_move(0, 0, 4);
    chk("zero_done", int'(done), 1);
    chk("zero_busy", int'(busy), 0);
    repeat (3) @(negedge clk);
    chk("zero_busy_cyc", busy_cyc - b0, 0);
    chk("zero_done_once", done_cnt - d0, 1);
    start_move(0, 2, 20);
    chk("noramp_dir", int'(dir_out), 0);
    wait_idle("noramp", 200);
    end_checks("noramp", 80, 2, 0);
    e = '{20, 20, 20, 20};
    chk_halves("noramp");
    start_move(1, 3, 2);
    wait_idle("short", 200);
    end_checks("short", 44, 3, 0);
    e = '{8, 6, 6, 8, 8, 8};
    chk_halves("short");
    start_move(1, 100, 4);
    wait_for("abh", 95, 1'b1, 200);
    abort = 1;
    @(negedge clk);
    abort = 0;
    wait_idle("abh", 50);
    chk("abh_done", int'(done), 1);
    chk("abh_left", int'(steps_left), 95);
    @(negedge clk);
    chk("abh_rises", rises - r0, 5);
    chk("abh_last_half", halves[halves.size() - 1], 4);
    chk("abh_done_once", done_cnt - d0, 1);
    start_move(1, 100, 4);
    wait_for("abl", 98, 1'b0, 200);
    abort = 1;
    @(negedge clk);
    abort = 0;
    chk("abl_busy", int'(busy), 0);
    chk("abl_done", int'(done), 1);
    chk("abl_pulse", int'(step_pulse), 0);
    chk("abl_left", int'(steps_left), 98);
    @(negedge clk);
    chk("abl_rises", rises - r0, 2);
    chk("abl_done_once", done_cnt - d0, 1);
    start_move(0, 6, 4);
    repeat (2) @(negedge clk);
    dir = 1; num_steps = 50; target_half = 2; start = 1;
    @(negedge clk);
    start = 0;
    chk("ign_dir", int'(dir_out), 0);
    chk("ign_left", int'(steps_left), 6);
    wait_idle("ign", 200);
    end_checks("ign", 72, 6, 0);
    e = '{8, 6, 6, 4, 4, 4, 4, 6, 6, 8, 8, 8};
    chk_halves("ign");
    start_move(1, 10, 4);
    wait_for("rstmid", 9, 1'b1, 100);
    rst = 1;
    #1;
    chk("rstmid_pulse", int'(step_pulse), 0);
    chk("rstmid_busy", int'(busy), 0);
    chk("rstmid_done", int'(done), 0);
    chk("rstmid_left", int'(steps_left), 0);
    @(negedge clk);
    rst = 0;
    repeat (2) @(negedge clk);
    ramp6("after_rst");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
